pipeline_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline (IF, DECODE, EXE, MEM, WB). It merges the load-use stall request, the EXE-stage taken-branch redirect, the multi-cycle multiply busy window and the data-memory wait handshake into one consistent set of per-stage register enables and bubble (flush) strobes. It also tracks data-memory timeouts and counts stall cycles for performance debug.

---
 rtl/general_defs_pkg.sv | 45 ++++
 rtl/pipeline_controller_mul_busy_counter.sv | 37 +++
 rtl/pipeline_controller.sv | 128 ++++++++++++
 tb/tb_pipeline_controller.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/general_defs_pkg.sv
// GENERAL_DEFS: shared pipeline types used by the pipeline controller and its neighbours.
// Holds the stall request type, the data-memory FSM states and the bundled stage control word.
package GENERAL_DEFS;

    typedef enum logic {
        NO_STALL       = 1'b0,
        STALL_PIPELINE = 1'b1
    } stall_pipeline_sig;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        MEM_ERR
    } mem_fsm_state_t;

    typedef struct packed {
        logic pcEn;
        logic ifIdEn;
        logic idExeEn;
        logic exeMemEn;
        logic memWbEn;
        logic flushIfId;
        logic flushIdExe;
        logic flushExeMem;
        logic flushMemWb;
    } pipe_ctrl_t;

    // One control word per priority row; a flush always travels with its enable.
    localparam pipe_ctrl_t CTRL_RUN = '{
        pcEn: 1'b1, ifIdEn: 1'b1, idExeEn: 1'b1, exeMemEn: 1'b1, memWbEn: 1'b1,
        flushIfId: 1'b0, flushIdExe: 1'b0, flushExeMem: 1'b0, flushMemWb: 1'b0};
    localparam pipe_ctrl_t CTRL_MEM_STALL = '{
        pcEn: 1'b0, ifIdEn: 1'b0, idExeEn: 1'b0, exeMemEn: 1'b0, memWbEn: 1'b1,
        flushIfId: 1'b0, flushIdExe: 1'b0, flushExeMem: 1'b0, flushMemWb: 1'b1};
    localparam pipe_ctrl_t CTRL_MUL_STALL = '{
        pcEn: 1'b0, ifIdEn: 1'b0, idExeEn: 1'b0, exeMemEn: 1'b1, memWbEn: 1'b1,
        flushIfId: 1'b0, flushIdExe: 1'b0, flushExeMem: 1'b1, flushMemWb: 1'b0};
    localparam pipe_ctrl_t CTRL_BRANCH = '{
        pcEn: 1'b1, ifIdEn: 1'b1, idExeEn: 1'b1, exeMemEn: 1'b1, memWbEn: 1'b1,
        flushIfId: 1'b1, flushIdExe: 1'b1, flushExeMem: 1'b0, flushMemWb: 1'b0};
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        pcEn: 1'b0, ifIdEn: 1'b0, idExeEn: 1'b1, exeMemEn: 1'b1, memWbEn: 1'b1,
        flushIfId: 1'b0, flushIdExe: 1'b1, flushExeMem: 1'b0, flushMemWb: 1'b0};

endpackage

// File: rtl/pipeline_controller_mul_busy_counter.sv
// Tracks how long a multiply still occupies EXE; busy while the down-counter is nonzero.
module mul_busy_counter #(
    parameter int MUL_LATENCY = 3
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic start_i,
    output logic busy_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Keeps counting through memory stalls because the multiplier itself never stops.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else if (start_i) begin
            cnt_d = 4'(MUL_LATENCY - 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != 4'd0);

    a_noStartWhileBusy: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(start_i && busy_o));

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory wait, multiply busy,
// branch redirect and load-use requests into per-stage enables and bubble strobes.
module pipeline_controller
    import GENERAL_DEFS::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  stall_pipeline_sig    load_use_stall_i,
    input  logic                 branch_taken_EXE_i,
    input  logic                 mul_start_EXE_i,
    input  logic                 dmem_req_MEM_i,
    input  logic                 dmem_ack_i,
    output logic                 pc_en_o,
    output logic                 if_id_en_o,
    output logic                 id_exe_en_o,
    output logic                 exe_mem_en_o,
    output logic                 mem_wb_en_o,
    output logic                 flush_if_id_o,
    output logic                 flush_id_exe_o,
    output logic                 flush_exe_mem_o,
    output logic                 flush_mem_wb_o,
    output logic                 mem_timeout_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o
);

    localparam int TO_W = $clog2(MEM_TIMEOUT);

    mem_fsm_state_t       memState_q;
    logic [TO_W-1:0]      timeoutCnt_q;
    logic [CNT_WIDTH-1:0] stallCnt_q;
    logic [CNT_WIDTH-1:0] stallCnt_d;
    logic                 memWait;
    logic                 mulBusy;
    pipe_ctrl_t           ctrl;

    mul_busy_counter #(
        .MUL_LATENCY(MUL_LATENCY)
    ) u_mulBusy (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .start_i(mul_start_EXE_i),
        .busy_o (mulBusy)
    );

    assign memWait = dmem_req_MEM_i && !dmem_ack_i;

    // MEM_ERR is terminal until reset so a hung memory freezes the core visibly.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            memState_q   <= RUN;
            timeoutCnt_q <= '0;
        end else begin
            case (memState_q)
                RUN: begin
                    if (memWait) begin
                        memState_q   <= MEM_WAIT;
                        timeoutCnt_q <= TO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack_i) begin
                        memState_q   <= RUN;
                        timeoutCnt_q <= '0;
                    end else if (timeoutCnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
                        memState_q <= MEM_ERR;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + TO_W'(1);
                    end
                end
                MEM_ERR: begin
                    memState_q <= MEM_ERR;
                end
                default: begin
                    memState_q   <= RUN;
                    timeoutCnt_q <= '0;
                end
            endcase
        end
    end

    // A deferred branch simply waits in EXE and wins the first cycle no stall row applies.
    always_comb begin
        ctrl = CTRL_RUN;
        if (!rst_n_i) begin
            ctrl = CTRL_RUN;
        end else if (memState_q == MEM_ERR || memWait) begin
            ctrl = CTRL_MEM_STALL;
        end else if (mulBusy) begin
            ctrl = CTRL_MUL_STALL;
        end else if (branch_taken_EXE_i) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use_stall_i == STALL_PIPELINE) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (!ctrl.pcEn && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign pc_en_o         = ctrl.pcEn;
    assign if_id_en_o      = ctrl.ifIdEn;
    assign id_exe_en_o     = ctrl.idExeEn;
    assign exe_mem_en_o    = ctrl.exeMemEn;
    assign mem_wb_en_o     = ctrl.memWbEn;
    assign flush_if_id_o   = ctrl.flushIfId;
    assign flush_id_exe_o  = ctrl.flushIdExe;
    assign flush_exe_mem_o = ctrl.flushExeMem;
    assign flush_mem_wb_o  = ctrl.flushMemWb;
    assign mem_timeout_o   = (memState_q == MEM_ERR);
    assign stall_cycles_o  = stallCnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: per-cycle expectations are queued when
// inputs are driven and popped when the combinational outputs are sampled mid-cycle.
module tb_pipeline_controller;
    import GENERAL_DEFS::*;

    localparam int CW = 32;

    // Expected control words, bit order pcEn..memWbEn then flushIfId..flushMemWb.
    localparam logic [8:0] E_NORM = 9'b11111_0000;
    localparam logic [8:0] E_MEM  = 9'b00001_0001;
    localparam logic [8:0] E_MUL  = 9'b00011_0010;
    localparam logic [8:0] E_BR   = 9'b11111_1100;
    localparam logic [8:0] E_LU   = 9'b00111_0100;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic        to;
        logic [31:0] stall;
    } expect_t;

    logic              clk = 1'b0;
    logic              rst_n;
    stall_pipeline_sig loadUse;
    logic              branch, mulStart, dmemReq, dmemAck;
    logic              pcEn, ifIdEn, idExeEn, exeMemEn, memWbEn;
    logic              flIfId, flIdExe, flExeMem, flMemWb;
    logic              memTimeout;
    logic [CW-1:0]     stallCycles;
    logic [8:0]        obsCtrl;

    expect_t expQ[$];
    int      totalChecks = 0;
    int      badChecks   = 0;
    int      expStall    = 0;

    always #5 clk = ~clk;

    pipeline_controller #(
        .MUL_LATENCY(3),
        .MEM_TIMEOUT(8),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .load_use_stall_i  (loadUse),
        .branch_taken_EXE_i(branch),
        .mul_start_EXE_i   (mulStart),
        .dmem_req_MEM_i    (dmemReq),
        .dmem_ack_i        (dmemAck),
        .pc_en_o           (pcEn),
        .if_id_en_o        (ifIdEn),
        .id_exe_en_o       (idExeEn),
        .exe_mem_en_o      (exeMemEn),
        .mem_wb_en_o       (memWbEn),
        .flush_if_id_o     (flIfId),
        .flush_id_exe_o    (flIdExe),
        .flush_exe_mem_o   (flExeMem),
        .flush_mem_wb_o    (flMemWb),
        .mem_timeout_o     (memTimeout),
        .stall_cycles_o    (stallCycles)
    );

    assign obsCtrl = {pcEn, ifIdEn, idExeEn, exeMemEn, memWbEn,
                      flIfId, flIdExe, flExeMem, flMemWb};

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs just after the edge and checks the outputs at the falling edge.
    task automatic applyStimulus(input string tag, input logic lu, input logic br, input logic ms,
                                 input logic req, input logic ack, input logic [8:0] eCtrl,
                                 input logic eTo);
        expect_t e;
        @(posedge clk);
        #1;
        loadUse  = lu ? STALL_PIPELINE : NO_STALL;
        branch   = br;
        mulStart = ms;
        dmemReq  = req;
        dmemAck  = ack;
        expQ.push_back('{ctrl: eCtrl, to: eTo, stall: 32'(expStall)});
        if (!eCtrl[8]) expStall++;
        @(negedge clk);
        e = expQ.pop_front();
        checkOutput({tag, ".ctrl"},  64'(obsCtrl),     64'(e.ctrl));
        checkOutput({tag, ".to"},    64'(memTimeout),  64'(e.to));
        checkOutput({tag, ".stall"}, 64'(stallCycles), 64'(e.stall));
    endtask

    initial begin
        rst_n    = 1'b0;
        loadUse  = STALL_PIPELINE;
        branch   = 1'b1;
        mulStart = 1'b0;
        dmemReq  = 1'b1;
        dmemAck  = 1'b0;
        #12;
        checkOutput("rst.ctrl",  64'(obsCtrl),     64'(E_NORM));
        checkOutput("rst.to",    64'(memTimeout),  64'd0);
        checkOutput("rst.stall", 64'(stallCycles), 64'd0);
        loadUse = NO_STALL;
        branch  = 1'b0;
        dmemReq = 1'b0;
        #10;
        rst_n = 1'b1;

        applyStimulus("idle0",   0, 0, 0, 0, 0, E_NORM, 0);
        applyStimulus("lu",      1, 0, 0, 0, 0, E_LU,   0);
        applyStimulus("idle1",   0, 0, 0, 0, 0, E_NORM, 0);
        applyStimulus("brLu",    1, 1, 0, 0, 0, E_BR,   0);
        applyStimulus("idle2",   0, 0, 0, 0, 0, E_NORM, 0);

        applyStimulus("mulGo",   0, 0, 1, 0, 0, E_NORM, 0);
        applyStimulus("mulB1",   0, 0, 0, 0, 0, E_MUL,  0);
        applyStimulus("mulB2",   0, 0, 0, 0, 0, E_MUL,  0);
        applyStimulus("mulDone", 0, 0, 0, 0, 0, E_NORM, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("memW%0d", i), 0, 0, 0, 1, 0, E_MEM, 0);
        end
        applyStimulus("memAck",  0, 0, 0, 1, 1, E_NORM, 0);
        applyStimulus("idle3",   0, 0, 0, 0, 0, E_NORM, 0);

        applyStimulus("ovMulGo", 0, 0, 1, 0, 0, E_NORM, 0);
        applyStimulus("ovMem1",  0, 1, 0, 1, 0, E_MEM,  0);
        applyStimulus("ovMem2",  0, 1, 0, 1, 0, E_MEM,  0);
        applyStimulus("ovBr",    0, 1, 0, 1, 1, E_BR,   0);
        applyStimulus("brMulGo", 0, 0, 1, 0, 0, E_NORM, 0);
        applyStimulus("brMul1",  0, 1, 0, 0, 0, E_MUL,  0);
        applyStimulus("brMul2",  0, 1, 0, 0, 0, E_MUL,  0);
        applyStimulus("brWin",   0, 1, 0, 0, 0, E_BR,   0);
        applyStimulus("idle4",   0, 0, 0, 0, 0, E_NORM, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("toW%0d", i), 0, 0, 0, 1, 0, E_MEM, 0);
        end
        applyStimulus("toErr",   0, 0, 0, 1, 0, E_MEM,  1);
        applyStimulus("errAck",  0, 0, 0, 1, 1, E_MEM,  1);
        applyStimulus("errIdle", 0, 1, 0, 0, 0, E_MEM,  1);

        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst.to",    64'(memTimeout),  64'd0);
        checkOutput("arst.stall", 64'(stallCycles), 64'd0);
        checkOutput("arst.ctrl",  64'(obsCtrl),     64'(E_NORM));
        loadUse = NO_STALL;
        branch  = 1'b0;
        dmemReq = 1'b0;
        dmemAck = 1'b0;
        #1;
        rst_n    = 1'b1;
        expStall = 0;
        applyStimulus("postRst", 0, 0, 0, 0, 0, E_NORM, 0);
        applyStimulus("postLu",  1, 0, 0, 0, 0, E_LU,   0);
        applyStimulus("postIdl", 0, 0, 0, 0, 0, E_NORM, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
